// File: rtl/store_mirror_uart_if.sv
// store_mirror_uart_if: data-memory store tap plus the UART mirror's line and status signals.
interface store_mirror_uart_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
);
    logic                        MemWrite;
    logic [DM_ADDRESS-1:0]       a;
    logic [DATA_W-1:0]           wd;
    logic                        tx;
    logic                        busy;
    logic                        fifo_full;
    logic                        overflow;
    logic [$clog2(FIFO_DEPTH):0] level;
    modport master (output MemWrite, a, wd, input tx, busy, fifo_full, overflow, level);
    modport slave (input MemWrite, a, wd, output tx, busy, fifo_full, overflow, level);
endinterface

// File: rtl/store_mirror_uart.sv
// store_mirror_uart: buffers data-memory stores and replays each as a 7-byte 8N1 UART frame.
module store_mirror_uart #(
    parameter int DM_ADDRESS   = 9,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input logic clk,
    input logic reset,
    store_mirror_uart_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int EW = DM_ADDRESS + DATA_W;
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [PW-1:0] wp, rp;
    logic [LW-1:0] level;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx, byte_idx;
    logic [55:0]   frame;
    logic          tx, overflow, pop, push, bit_end;

    assign head    = mem[rp];
    assign pop     = state == IDLE && level != '0;
    // a full buffer still takes the store when the engine frees a slot on the same edge
    assign push    = bus.MemWrite && (level != LW'(FIFO_DEPTH) || pop);
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk)
        if (push) mem[wp] <= {bus.a, bus.wd};

    always_ff @(posedge clk) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
            tx       <= 1'b1;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level <= level + LW'(push) - LW'(pop);
            if (bus.MemWrite && !push) overflow <= 1'b1;
            cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    tx <= !pop;
                    if (pop) begin
                        frame <= {8'hA5, 16'(head[EW-1:DATA_W]), head[31:0]};
                        state <= START;
                    end
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    tx      <= frame[48];
                    bit_idx <= '0;
                end
                // the current byte lives in frame[55:48] and is shifted right one bit per bit time
                DATA: if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        bit_idx      <= bit_idx + 1'b1;
                        tx           <= frame[49];
                        frame[55:48] <= {1'b0, frame[55:49]};
                    end
                end
                STOP: if (bit_end) begin
                    frame <= {frame[47:0], 8'h00};
                    if (byte_idx < 3'd6) begin
                        byte_idx <= byte_idx + 1'b1;
                        state    <= START;
                        tx       <= 1'b0;
                    end else begin
                        byte_idx <= '0;
                        state    <= IDLE;
                        tx       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx        = tx;
    assign bus.busy      = state != IDLE || level != '0;
    assign bus.fifo_full = level == LW'(FIFO_DEPTH);
    assign bus.overflow  = overflow;
    assign bus.level     = level;
endmodule

// File: tb/tb_store_mirror_uart.sv
// tb_store_mirror_uart: directed and random stores checked against a frame-timing model and a UART line decoder.
module tb_store_mirror_uart;
    localparam int C  = 4;
    localparam int D  = 8;
    localparam int AW = 9;
    localparam int FT = 70 * C;

    logic clk = 1'b0;
    logic reset = 1'b1;
    store_mirror_uart_if #(.DM_ADDRESS(AW), .DATA_W(32), .FIFO_DEPTH(D)) bus ();
    store_mirror_uart #(.DM_ADDRESS(AW), .DATA_W(32), .FIFO_DEPTH(D), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int next_pop = 0;
    int mlev = 0;
    bit mover = 1'b0;
    logic [7:0] exp_q[$];

    int cyc = 0;
    int stop_bad = 0;
    int dt;
    logic [7:0] db;
    logic [7:0] rx_q[$];
    int rx_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    // line decoder: samples mid-bit, records each byte with the cycle its start bit began
    initial forever begin
        @(negedge clk);
        if (reset === 1'b0 && bus.tx === 1'b0) begin
            dt = cyc;
            repeat (C / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (C) @(negedge clk);
                db[k] = bus.tx;
            end
            repeat (C) @(negedge clk);
            if (bus.tx !== 1'b1) stop_bad++;
            rx_q.push_back(db);
            rx_t.push_back(dt);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // one clock: drive inputs, advance the model by the same edge, then compare
    task automatic step(input logic mw, input logic [AW-1:0] aa, input logic [31:0] dd, input logic rs);
        bit pop, acc;
        logic [15:0] a16;
        bus.MemWrite = mw;
        bus.a = aa;
        bus.wd = dd;
        reset = rs;
        @(posedge clk);
        n++;
        if (rs) begin
            mlev = 0;
            next_pop = 0;
            mover = 1'b0;
            exp_q.delete();
        end else begin
            pop = mlev > 0 && n >= next_pop;
            acc = mw && (mlev < D || pop);
            if (pop) begin
                mlev--;
                next_pop = n + FT + 1;
            end
            if (acc) begin
                mlev++;
                a16 = 16'(aa);
                exp_q.push_back(8'hA5);
                exp_q.push_back(a16[15:8]);
                exp_q.push_back(a16[7:0]);
                exp_q.push_back(dd[31:24]);
                exp_q.push_back(dd[23:16]);
                exp_q.push_back(dd[15:8]);
                exp_q.push_back(dd[7:0]);
            end
            if (mw && !acc) mover = 1'b1;
        end
        #1;
        chk("level", 32'(bus.level), 32'(mlev));
        chk("fifo_full", 32'(bus.fifo_full), 32'(mlev == D));
        chk("overflow", 32'(bus.overflow), 32'(mover));
        chk("busy", 32'(bus.busy), 32'(mlev != 0 || n < next_pop - 1));
        if (n >= next_pop - 1) chk("tx_idle", 32'(bus.tx), 32'd1);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        while (mlev > 0 || n < next_pop - 1) step(1'b0, '0, '0, 1'b0);
        idle(50);
    endtask

    task automatic check_frames(input int nf, input bit gaps);
        chk("byte_count", 32'(rx_q.size()), 32'(exp_q.size()));
        if (nf >= 0) chk("frame_count", 32'(rx_q.size()), 32'(nf * 7));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) chk("frame_byte", 32'(rx_q[i]), 32'(exp_q[i]));
        if (gaps)
            for (int k = 7; k + 6 < rx_t.size(); k += 7) chk("frame_gap", 32'(rx_t[k] - rx_t[k - 7]), 32'(FT + 1));
        chk("stop_bits", 32'(stop_bad), 32'd0);
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        stop_bad = 0;
    endtask

    initial begin
        int peak, p;
        bus.MemWrite = 1'b0;
        bus.a = '0;
        bus.wd = '0;
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        chk("reset_tx", 32'(bus.tx), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_level", 32'(bus.level), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        chk("reset_full", 32'(bus.fifo_full), 32'd0);

        step(1'b1, 9'h1F3, 32'hDEADBEEF, 1'b0);
        chk("latency_tx_high", 32'(bus.tx), 32'd1);
        step(1'b0, '0, '0, 1'b0);
        chk("latency_tx_low", 32'(bus.tx), 32'd0);
        idle(FT - 1);
        chk("frame_end_busy", 32'(bus.busy), 32'd1);
        idle(1);
        chk("frame_done_busy", 32'(bus.busy), 32'd0);
        drain();
        chk("single_b1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'hxx), 32'h01);
        chk("single_b2", 32'(rx_q.size() > 2 ? rx_q[2] : 8'hxx), 32'hF3);
        check_frames(1, 1'b0);

        peak = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, AW'(i), 32'h100 + 32'(i), 1'b0);
            if (int'(bus.level) > peak) peak = int'(bus.level);
        end
        chk("burst_peak", 32'(peak >= 7), 32'd1);
        chk("burst_overflow", 32'(bus.overflow), 32'd0);
        drain();
        check_frames(8, 1'b1);

        step(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, AW'($urandom), $urandom, 1'b0);
            if (i == 8) begin
                chk("ovf_full", 32'(bus.fifo_full), 32'd1);
                chk("ovf_not_yet", 32'(bus.overflow), 32'd0);
            end
            if (i == 9) chk("ovf_set", 32'(bus.overflow), 32'd1);
        end
        drain();
        chk("ovf_held", 32'(bus.overflow), 32'd1);
        check_frames(9, 1'b1);

        step(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, AW'($urandom), $urandom, 1'b0);
        chk("pp_full", 32'(bus.level), 32'd8);
        while (n + 1 < next_pop) step(1'b0, '0, '0, 1'b0);
        step(1'b1, 9'h0AA, 32'h12345678, 1'b0);
        chk("pp_level", 32'(bus.level), 32'd8);
        chk("pp_overflow", 32'(bus.overflow), 32'd0);
        drain();
        check_frames(10, 1'b1);

        step(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, AW'($urandom), $urandom, 1'b0);
        p = next_pop - FT - 1;
        while (n < p + 3 * 10 * C + 2 * C) step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        chk("rst_mid_tx", 32'(bus.tx), 32'd1);
        chk("rst_mid_level", 32'(bus.level), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_overflow", 32'(bus.overflow), 32'd0);
        idle(60);
        rx_q.delete();
        rx_t.delete();
        stop_bad = 0;
        step(1'b1, AW'($urandom), $urandom, 1'b0);
        drain();
        check_frames(1, 1'b0);

        step(1'b0, '0, '0, 1'b1);
        idle(1000);
        chk("quiet_frames", 32'(rx_q.size()), 32'd0);

        for (int i = 0; i < 2000; i++) step($urandom_range(0, 99) < 4, AW'($urandom), $urandom, 1'b0);
        drain();
        check_frames(-1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
